target_sequencer: RTL and testbench
===================================

Name: target_sequencer

Overview:
Run-time controller for the PWM target word. It builds a 32-bit staged value one byte at a time from switch inputs and debounced push-buttons. On a commit request it transfers the staged value to the active target seen by the PWM core. The transfer happens only on PWM period boundaries, either in one step or as a rate-limited ramp. It sits between the switch/button inputs and the PWM core's target input.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a button press or release is accepted (minimum 2)
RAMP_STEP, 0, maximum change of target per period_end; 0 = apply in a single step
RESET_TARGET, 32'h4996CDD1, value of target and staged after reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
byte_sel  input  2  byte lane to edit: 0 = [7:0] ... 3 = [31:24]
sw_value  input  6  user value; lane byte = {sw_value, 2'b00}
btn_load  input  1  raw load button, active-high, already synchronised to clk
btn_commit  input  1  raw commit button, active-high, already synchronised to clk
period_end  input  1  one-cycle pulse from the PWM core at each PWM period boundary
target  output  32  active target driven to the PWM core
staged  output  32  value under edit
pending  output  1  high while a commit is in progress (FSM not IDLE)
commit_ack  output  1  one-cycle pulse when target first equals staged after a commit

Behaviour:
- Reset values:
  - target = staged = RESET_TARGET
  - pending = 0, commit_ack = 0, FSM = IDLE
  - debouncers cleared to the released state with counters at 0
- Reset mid-ramp abandons the ramp immediately.
- Debounce, per button:
  - Accepted state toggles only after the raw input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A press pulse (1 cycle) is emitted on the released->pressed transition only.
  - A held button gives exactly one pulse.
  - Latency: raw rise to pulse = DEBOUNCE_CYCLES+1 cycles.
- Load pulse: the staged lane selected by byte_sel becomes {sw_value,2'b00} on the next edge; other lanes are unchanged. Load is accepted in every FSM state.
- FSM states: IDLE, WAIT_PERIOD, RAMP, DONE.
  - IDLE: a commit pulse goes to WAIT_PERIOD and sets pending=1.
  - WAIT_PERIOD: on period_end:
    - RAMP_STEP==0: target <= staged in that same edge, then go to DONE.
    - RAMP_STEP>0: take one ramp step in that same edge, then go to RAMP.
  - RAMP: on each period_end, target moves toward staged by min(|staged−target|, RAMP_STEP).
    - Unsigned 33-bit difference; no overshoot, no wrap.
    - When target==staged after the update, go to DONE.
  - DONE: commit_ack=1 for this single cycle, pending drops to 0, then return to IDLE.
- Commit pulses outside IDLE are ignored (no queueing).
- Load during WAIT_PERIOD/RAMP: the ramp tracks the new staged value from the next period_end onward.
- Load and commit pulses in the same cycle: the load is applied first; WAIT_PERIOD then uses the updated staged.
- period_end in the same cycle as the IDLE->WAIT_PERIOD transition is not consumed; the next period_end is required.
- If target already equals staged at commit: WAIT_PERIOD still waits for period_end, then goes to DONE.
- target changes only on a period_end edge, never between boundaries.

Decomposition:
- Shared package pwm_ctrl_pkg holds:
  - state_t enum {IDLE, WAIT_PERIOD, RAMP, DONE}
  - constant DEFAULT_TARGET = 32'h4996CDD1, also used as the RESET_TARGET default
  - localparam for the byte-lane count (4)
- One sub-module: button_debounce (params DEBOUNCE_CYCLES; ports clk, rst, raw, pressed, press_pulse), instantiated twice.
- Ramp arithmetic and the FSM stay in the top module.

Test Plan:
- Reset, then DEBOUNCE_CYCLES=4, byte_sel=2, sw_value=6'h3F, clean load press of 6 cycles -> staged=32'h49FCCDD1; target unchanged at 32'h4996CDD1; exactly one load pulse.
- Bounce (3 cycles high, 1 low, 3 high) on btn_load -> no load. Then 4 stable high cycles -> one load pulse, 5 cycles after the last rise.
- RAMP_STEP=0, staged=32'h49FCCDD1, commit, period_end 10 cycles later -> pending=1 until then; target=32'h49FCCDD1 after that edge; commit_ack single pulse on the next cycle; pending=0.
- RAMP_STEP=32'h00100000, staged−target=32'h00660000 -> target advances by 0x100000 on each of 6 period_ends, then the final 0x60000 on the 7th; commit_ack after the 7th; no overshoot.
- Downward ramp (staged < target) plus a second commit mid-ramp -> ramp decrements correctly; the second commit is ignored; a single commit_ack.
- Load and commit in the same cycle with period_end also in that cycle -> target unchanged until the next period_end, which applies the updated staged. rst asserted mid-ramp -> target=RESET_TARGET, pending=0 on the next edge.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM run-time control blocks.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PERIOD,
        RAMP,
        DONE
    } state_t;

    localparam logic [31:0] DEFAULT_TARGET = 32'h4996CDD1;
    localparam int unsigned NUM_LANES      = 4;
    localparam int unsigned LANE_W         = 8;

    // Replace one byte lane of a word, leaving the other lanes intact.
    function automatic logic [31:0] set_lane(input logic [31:0] word,
                                             input logic [1:0]  sel,
                                             input logic [7:0]  val);
        logic [31:0] res;
        res = word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sel == 2'(i)) begin
                res[i*LANE_W +: LANE_W] = val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Counter-based debouncer: the accepted level follows the raw input only after
// it has disagreed for long enough; a one-cycle pulse marks each accepted press.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pressed,
    output logic press_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic             pulse_q, pulse_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        pulse_d = 1'b0;
        if (raw != state_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                state_d = raw;
                cnt_d   = '0;
                pulse_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    assign pressed     = state_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/target_sequencer.sv
// Stages a 32-bit PWM target byte by byte and transfers it to the active target
// on PWM period boundaries, either at once or as a rate-limited ramp.
module target_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] RAMP_STEP       = 32'd0,
    parameter logic [31:0] RESET_TARGET    = DEFAULT_TARGET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  byte_sel,
    input  logic [5:0]  sw_value,
    input  logic        btn_load,
    input  logic        btn_commit,
    input  logic        period_end,
    output logic [31:0] target,
    output logic [31:0] staged,
    output logic        pending,
    output logic        commit_ack
);

    logic load_pulse, commit_pulse;
    logic load_held, commit_held;
    logic unused_held;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk         (clk),
        .rst         (rst),
        .raw         (btn_load),
        .pressed     (load_held),
        .press_pulse (load_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit_db (
        .clk         (clk),
        .rst         (rst),
        .raw         (btn_commit),
        .pressed     (commit_held),
        .press_pulse (commit_pulse)
    );

    assign unused_held = load_held ^ commit_held;

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] staged_q, staged_d;

    // One ramp step toward staged, computed on 33 bits so the magnitude never wraps.
    logic        ramp_up;
    logic [32:0] ramp_diff;
    logic [31:0] ramp_delta;
    logic [31:0] ramp_next;

    always_comb begin
        ramp_up    = staged_q >= target_q;
        ramp_diff  = ramp_up ? ({1'b0, staged_q} - {1'b0, target_q})
                             : ({1'b0, target_q} - {1'b0, staged_q});
        ramp_delta = (ramp_diff > {1'b0, RAMP_STEP}) ? RAMP_STEP : ramp_diff[31:0];
        ramp_next  = ramp_up ? (target_q + ramp_delta) : (target_q - ramp_delta);
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        staged_d = staged_q;

        if (load_pulse) begin
            staged_d = set_lane(staged_q, byte_sel, {sw_value, 2'b00});
        end

        unique case (state_q)
            IDLE: begin
                if (commit_pulse) begin
                    state_d = WAIT_PERIOD;
                end
            end
            WAIT_PERIOD: begin
                if (period_end) begin
                    if (RAMP_STEP == '0) begin
                        target_d = staged_q;
                        state_d  = DONE;
                    end else begin
                        target_d = ramp_next;
                        state_d  = (ramp_next == staged_q) ? DONE : RAMP;
                    end
                end
            end
            RAMP: begin
                if (period_end) begin
                    target_d = ramp_next;
                    if (ramp_next == staged_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= RESET_TARGET;
            staged_q <= RESET_TARGET;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            staged_q <= staged_d;
        end
    end

    assign target     = target_q;
    assign staged     = staged_q;
    assign pending    = (state_q != IDLE);
    assign commit_ack = (state_q == DONE);

endmodule

// File: tb/tb_target_sequencer.sv
// Self-checking bench for target_sequencer: one instance applies commits in a
// single step, a second ramps; both share the same stimulus.
module tb_target_sequencer;
    import pwm_ctrl_pkg::*;

    localparam int unsigned DEB  = 4;
    localparam logic [31:0] STEP = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  byte_sel = '0;
    logic [5:0]  sw_value = '0;
    logic        btn_load = 1'b0;
    logic        btn_commit = 1'b0;
    logic        period_end = 1'b0;

    logic [31:0] target0, staged0, target1, staged1;
    logic        pending0, ack0, pending1, ack1;

    always #5 clk = ~clk;

    target_sequencer #(.DEBOUNCE_CYCLES(DEB), .RAMP_STEP(32'd0), .RESET_TARGET(DEFAULT_TARGET)) dut0 (
        .clk(clk), .rst(rst), .byte_sel(byte_sel), .sw_value(sw_value),
        .btn_load(btn_load), .btn_commit(btn_commit), .period_end(period_end),
        .target(target0), .staged(staged0), .pending(pending0), .commit_ack(ack0)
    );

    target_sequencer #(.DEBOUNCE_CYCLES(DEB), .RAMP_STEP(STEP), .RESET_TARGET(DEFAULT_TARGET)) dut1 (
        .clk(clk), .rst(rst), .byte_sel(byte_sel), .sw_value(sw_value),
        .btn_load(btn_load), .btn_commit(btn_commit), .period_end(period_end),
        .target(target1), .staged(staged1), .pending(pending1), .commit_ack(ack1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected targets queued when a period_end is driven,
    // compared once the boundary edge has passed.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        pe_edge = 1'b0;
    int          acks0 = 0, acks1 = 0, loads0 = 0;

    always @(posedge clk) pe_edge <= period_end;

    always @(negedge clk) begin
        if (ack0) acks0++;
        if (ack1) acks1++;
        if (dut0.load_pulse) loads0++;
        if (pe_edge) begin
            if (q0.size() > 0) check("pe_target0", target0, q0.pop_front());
            if (q1.size() > 0) check("pe_target1", target1, q1.pop_front());
        end
    end

    logic [31:0] m_s;
    logic [31:0] m1;

    function automatic logic [31:0] ramp_model(input logic [31:0] t, input logic [31:0] s);
        if (s >= t) return ((s - t) > STEP) ? t + STEP : s;
        else        return ((t - s) > STEP) ? t - STEP : s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        m_s = DEFAULT_TARGET;
        m1  = DEFAULT_TARGET;
        tick(1);
    endtask

    task automatic press_load(input logic [1:0] sel, input logic [5:0] val);
        byte_sel = sel;
        sw_value = val;
        btn_load = 1'b1;
        tick(6);
        btn_load = 1'b0;
        m_s[int'(sel)*8 +: 8] = {val, 2'b00};
        tick(7);
    endtask

    task automatic press_commit();
        btn_commit = 1'b1;
        tick(7);
        btn_commit = 1'b0;
        tick(1);
    endtask

    task automatic pulse_pe(input bit exp0, input bit exp1);
        if (exp0) q0.push_back(m_s);
        if (exp1) begin
            m1 = ramp_model(m1, m_s);
            q1.push_back(m1);
        end
        period_end = 1'b1;
        tick(1);
        period_end = 1'b0;
    endtask

    initial begin
        int lat;

        // Reset state
        do_reset();
        check("rst_target0", target0, DEFAULT_TARGET);
        check("rst_staged0", staged0, DEFAULT_TARGET);
        check("rst_pending0", pending0, 0);
        check("rst_ack0", ack0, 0);
        check("rst_target1", target1, DEFAULT_TARGET);

        // Clean load press
        press_load(2'd2, 6'h3F);
        check("load_staged", staged0, 32'h49FCCDD1);
        check("load_target_hold", target0, DEFAULT_TARGET);
        check("load_pulses", loads0, 1);

        // Bounce then stable press on lane 0
        byte_sel = 2'd0;
        sw_value = 6'h01;
        btn_load = 1'b1;
        tick(3);
        btn_load = 1'b0;
        tick(1);
        btn_load = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (dut0.load_pulse && lat == 0) lat = k;
        end
        btn_load = 1'b0;
        tick(7);
        check("bounce_latency", lat, 5);
        check("bounce_staged", staged0, 32'h49FCCD04);
        check("bounce_pulses", loads0, 2);

        // Single-step commit (dut0) and upward ramp of 0x660000 (dut1)
        do_reset();
        press_load(2'd2, 6'h3F);
        press_commit();
        tick(3);
        check("wait_pending0", pending0, 1);
        check("wait_pending1", pending1, 1);
        check("wait_target0", target0, DEFAULT_TARGET);
        pulse_pe(1'b1, 1'b1);
        check("step_ack0", ack0, 1);
        check("ramp_noack1", ack1, 0);
        tick(1);
        check("step_ack0_once", ack0, 0);
        check("step_pending0", pending0, 0);
        for (int k = 2; k <= 7; k++) begin
            tick(2);
            check("ramp_hold", target1, m1);
            pulse_pe(1'b0, 1'b1);
            if (k < 7) check("ramp_early_ack", ack1, 0);
        end
        check("ramp_ack1", ack1, 1);
        check("ramp_final", target1, 32'h49FCCDD1);
        tick(1);
        check("ramp_pending1", pending1, 0);
        tick(1);
        check("acks0_b", acks0, 1);
        check("acks1_b", acks1, 1);

        // Downward ramp with a second commit mid-ramp
        press_load(2'd2, 6'h30);
        check("down_staged", staged1, 32'h49C0CDD1);
        press_commit();
        tick(2);
        pulse_pe(1'b1, 1'b1);
        tick(1);
        press_commit();
        tick(2);
        pulse_pe(1'b1, 1'b1);
        for (int k = 0; k < 8 && m1 != m_s; k++) begin
            tick(2);
            pulse_pe(1'b0, 1'b1);
        end
        check("down_ack1", ack1, 1);
        check("down_final", target1, 32'h49C0CDD1);
        tick(2);
        check("acks0_c", acks0, 3);
        check("acks1_c", acks1, 2);

        // Load and commit in one cycle with period_end also in that cycle
        byte_sel = 2'd1;
        sw_value = 6'h0A;
        btn_load = 1'b1;
        btn_commit = 1'b1;
        tick(5);
        period_end = 1'b1;
        check("same_cycle_pulse", dut0.commit_pulse, 1);
        tick(1);
        period_end = 1'b0;
        m_s[15:8] = 8'h28;
        check("same_target0", target0, 32'h49C0CDD1);
        check("same_target1", target1, 32'h49C0CDD1);
        check("same_staged0", staged0, 32'h49C028D1);
        check("same_pending0", pending0, 1);
        check("same_pending1", pending1, 1);
        tick(3);
        btn_load = 1'b0;
        btn_commit = 1'b0;
        tick(6);
        check("same_hold1", target1, 32'h49C0CDD1);
        pulse_pe(1'b1, 1'b1);
        check("same_ack0", ack0, 1);
        check("same_ack1", ack1, 1);

        // Reset mid-ramp
        tick(2);
        press_load(2'd3, 6'h00);
        press_commit();
        tick(2);
        pulse_pe(1'b1, 1'b1);
        tick(1);
        check("mid_pending1", pending1, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_target1", target1, DEFAULT_TARGET);
        check("mid_rst_staged1", staged1, DEFAULT_TARGET);
        check("mid_rst_pending1", pending1, 0);
        check("mid_rst_target0", target0, DEFAULT_TARGET);
        tick(2);
        pulse_pe(1'b0, 1'b0);
        check("post_rst_target1", target1, DEFAULT_TARGET);
        check("post_rst_ack1", ack1, 0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
